// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways) between IF and IMemory.
// Same-cycle hits, multi-beat line refill, fence.i flush, saturating hit/miss counters.
module icache_assoc #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int WAYS       = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_valid,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              dbgState
);

  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(SETS);
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_DEPTH = SETS * LINE_WORDS;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } cacheState_t;

  cacheState_t state, stateNext;

  logic [OFF_W-1:0] reqOff;
  logic [IDX_W-1:0] reqIdx;
  logic [TAG_W-1:0] reqTag;

  assign reqOff = cpu_addr[OFF_W-1:0];
  assign reqIdx = cpu_addr[OFF_W +: IDX_W];
  assign reqTag = cpu_addr[ADDR_W-1 -: TAG_W];

  logic [SETS-1:0]   validBits [WAYS];
  logic [SETS-1:0]   lruBits;
  logic [TAG_W-1:0]  tagMem    [WAYS][SETS];
  logic [DATA_W-1:0] dataMem   [WAYS][LINE_DEPTH];

  logic [TAG_W-1:0] refTag;
  logic [IDX_W-1:0] refIdx;
  logic [OFF_W-1:0] beat;
  logic             victimReg;

  logic [WAYS-1:0]   wayMatch;
  logic              anyHit;
  logic              hitWay;
  logic              victim;
  logic [DATA_W-1:0] hitWord;

  logic startMiss;
  logic doHit;
  logic beatWrite;
  logic lineDone;

  // Lookup: lruBits holds the way to evict next; an invalid way always wins,
  // the lowest-numbered one first.
  always_comb begin
    wayMatch = '0;
    hitWay   = 1'b0;
    hitWord  = '0;
    victim   = (WAYS == 2) ? lruBits[reqIdx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      wayMatch[w] = validBits[w][reqIdx] && (tagMem[w][reqIdx] == reqTag);
      if (wayMatch[w]) begin
        hitWay  = 1'(w);
        hitWord = dataMem[w][{reqIdx, reqOff}];
      end
      if (!validBits[w][reqIdx]) begin
        victim = 1'(w);
      end
    end
  end

  assign anyHit   = |wayMatch;
  assign dbgState = (state == REFILL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Refill handshake: mem_req stays high with mem_addr stable until the cycle
  // mem_ack is seen; mem_data is taken in that same cycle and the beat advances.
  always_comb begin
    stateNext = state;
    cpu_valid = 1'b0;
    cpu_data  = '0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    startMiss = 1'b0;
    doHit     = 1'b0;
    beatWrite = 1'b0;
    lineDone  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (anyHit) begin
            cpu_valid = 1'b1;
            cpu_data  = hitWord;
            doHit     = 1'b1;
          end else begin
            startMiss = 1'b1;
            stateNext = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {refTag, refIdx, beat};
        if (flush) begin
          stateNext = IDLE;
        end else if (mem_ack) begin
          beatWrite = 1'b1;
          if (beat == OFF_W'(LINE_WORDS - 1)) begin
            lineDone  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WAYS; w++) begin
        validBits[w] <= '0;
      end
      lruBits   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      refTag    <= '0;
      refIdx    <= '0;
      beat      <= '0;
      victimReg <= 1'b0;
    end else begin
      if (doHit) begin
        if (hit_cnt != '1) begin
          hit_cnt <= hit_cnt + 1'b1;
        end
        if (WAYS == 2) begin
          lruBits[reqIdx] <= ~hitWay;
        end
      end
      if (startMiss) begin
        refTag    <= reqTag;
        refIdx    <= reqIdx;
        beat      <= '0;
        victimReg <= victim;
        if (miss_cnt != '1) begin
          miss_cnt <= miss_cnt + 1'b1;
        end
      end
      if (beatWrite) begin
        beat <= beat + 1'b1;
      end
      if (lineDone) begin
        for (int w = 0; w < WAYS; w++) begin
          if (victimReg == 1'(w)) begin
            validBits[w][refIdx] <= 1'b1;
          end
        end
        if (WAYS == 2) begin
          lruBits[refIdx] <= ~victimReg;
        end
      end
      // Flush last so it overrides any line completing in the same cycle.
      if (flush) begin
        for (int w = 0; w < WAYS; w++) begin
          validBits[w] <= '0;
        end
      end
    end
  end

  // Data and tag arrays need no reset; the valid bits gate every use.
  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      if (victimReg == 1'(w)) begin
        if (beatWrite) begin
          dataMem[w][{refIdx, beat}] <= mem_data;
        end
        if (lineDone) begin
          tagMem[w][refIdx] <= refTag;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: a 2-way/16-bit-counter instance and a 1-way/4-bit-counter
// instance share stimulus and are checked each cycle against a line-level model.
module tb_icache_assoc;

  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int SETS = 16;
  localparam int LW   = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          cpuReq  = 1'b0;
  logic          flush   = 1'b0;
  logic [AW-1:0] cpuAddr = '0;

  logic [DW-1:0] cpuDataA, cpuDataB, memDataA, memDataB;
  logic          cpuValidA, cpuValidB, memReqA, memReqB, memAckA, memAckB, dbgA, dbgB;
  logic [AW-1:0] memAddrA, memAddrB;
  logic [15:0]   hitA, missA;
  logic [3:0]    hitB, missB;

  icache_assoc #(.ADDR_W(AW), .DATA_W(DW), .SETS(SETS), .LINE_WORDS(LW), .WAYS(2), .CNT_W(16)) dutA (
    .clock(clock), .reset(reset), .cpu_req(cpuReq), .cpu_addr(cpuAddr),
    .cpu_data(cpuDataA), .cpu_valid(cpuValidA), .flush(flush),
    .mem_req(memReqA), .mem_addr(memAddrA), .mem_data(memDataA), .mem_ack(memAckA),
    .hit_cnt(hitA), .miss_cnt(missA), .dbgState(dbgA)
  );

  icache_assoc #(.ADDR_W(AW), .DATA_W(DW), .SETS(SETS), .LINE_WORDS(LW), .WAYS(1), .CNT_W(4)) dutB (
    .clock(clock), .reset(reset), .cpu_req(cpuReq), .cpu_addr(cpuAddr),
    .cpu_data(cpuDataB), .cpu_valid(cpuValidB), .flush(flush),
    .mem_req(memReqB), .mem_addr(memAddrB), .mem_data(memDataB), .mem_ack(memAckB),
    .hit_cnt(hitB), .miss_cnt(missB), .dbgState(dbgB)
  );

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: acks a beat once it has waited waitCfg cycles.
  int waitCfg = 0;
  int waitA = 0;
  int waitB = 0;
  assign memDataA = memf(memAddrA);
  assign memDataB = memf(memAddrB);
  assign memAckA  = memReqA && (waitA >= waitCfg);
  assign memAckB  = memReqB && (waitB >= waitCfg);
  always @(posedge clock) begin
    if (!memReqA || memAckA) waitA <= 0; else waitA <= waitA + 1;
    if (!memReqB || memAckB) waitB <= 0; else waitB <= waitB + 1;
  end

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // Reference model: resident lines per set, eviction choice, refill progress.
  bit mValid [2][2][SETS];
  int mTag   [2][2][SETS];
  bit mLru   [2][SETS];
  bit mBusy  [2];
  int mBeat  [2];
  int mBase  [2];
  int mIdx   [2];
  int mTagR  [2];
  int mVict  [2];
  int mHits  [2];
  int mMiss  [2];
  int mWays  [2] = '{2, 1};
  int mMax   [2] = '{65535, 15};
  bit lastHit[2];

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < SETS; s++) begin
        mValid[d][0][s] = 0; mValid[d][1][s] = 0; mLru[d][s] = 0;
      end
      mBusy[d] = 0; mBeat[d] = 0; mHits[d] = 0; mMiss[d] = 0;
    end
  endtask

  task automatic step();
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      logic        obsV, obsR, ack;
      logic [31:0] obsD, obsA, obsH, obsM, expD, expA;
      int a, idx, tag, hitWay, v;
      bit preBusy;
      if (d == 0) begin
        obsV = cpuValidA; obsD = cpuDataA; obsR = memReqA; obsA = {2'b00, memAddrA};
        obsH = {16'd0, hitA}; obsM = {16'd0, missA}; ack = memAckA;
      end else begin
        obsV = cpuValidB; obsD = cpuDataB; obsR = memReqB; obsA = {2'b00, memAddrB};
        obsH = {28'd0, hitB}; obsM = {28'd0, missB}; ack = memAckB;
      end
      a   = int'(cpuAddr);
      idx = (a / LW) % SETS;
      tag = a / (LW * SETS);
      hitWay = -1;
      if (!mBusy[d] && cpuReq)
        for (int w = 0; w < mWays[d]; w++)
          if (mValid[d][w][idx] && mTag[d][w][idx] == tag) hitWay = w;
      expD = (hitWay >= 0) ? memf(cpuAddr) : 32'd0;
      expA = mBusy[d] ? 32'(mBase[d] + mBeat[d]) : 32'd0;
      chk("cpu_valid", d, 32'(obsV), 32'(hitWay >= 0));
      chk("cpu_data", d, obsD, expD);
      chk("mem_req", d, 32'(obsR), 32'(mBusy[d]));
      chk("mem_addr", d, obsA, expA);
      chk("hit_cnt", d, obsH, 32'(mHits[d]));
      chk("miss_cnt", d, obsM, 32'(mMiss[d]));
      lastHit[d] = obsV;

      preBusy = mBusy[d];
      if (!preBusy && cpuReq) begin
        if (hitWay >= 0) begin
          if (mHits[d] < mMax[d]) mHits[d]++;
          if (mWays[d] == 2) mLru[d][idx] = (hitWay == 0);
        end else begin
          if (mMiss[d] < mMax[d]) mMiss[d]++;
          mBusy[d] = 1; mBeat[d] = 0;
          mBase[d] = a - (a % LW); mIdx[d] = idx; mTagR[d] = tag;
          v = (mWays[d] == 2) ? int'(mLru[d][idx]) : 0;
          for (int w = mWays[d] - 1; w >= 0; w--)
            if (!mValid[d][w][idx]) v = w;
          mVict[d] = v;
        end
      end
      if (preBusy) begin
        if (flush) mBusy[d] = 0;
        else if (ack) begin
          mBeat[d]++;
          if (mBeat[d] == LW) begin
            mValid[d][mVict[d]][mIdx[d]] = 1;
            mTag[d][mVict[d]][mIdx[d]] = mTagR[d];
            if (mWays[d] == 2) mLru[d][mIdx[d]] = (mVict[d] == 0);
            mBusy[d] = 0;
          end
        end
      end
      if (flush)
        for (int s = 0; s < SETS; s++) begin
          mValid[d][0][s] = 0; mValid[d][1][s] = 0;
        end
    end
    @(posedge clock);
    #1;
  endtask

  // Requests one address until both caches report a hit; pen = cycles from request to hit.
  task automatic fetch(input logic [AW-1:0] a, output int penA, output int penB);
    penA = -1; penB = -1;
    cpuReq = 1'b1; cpuAddr = a;
    for (int k = 0; k < 80 && (penA < 0 || penB < 0); k++) begin
      step();
      if (penA < 0 && lastHit[0]) penA = k;
      if (penB < 0 && lastHit[1]) penB = k;
    end
    cpuReq = 1'b0;
    chk("fetch_done", 0, 32'(penA >= 0 && penB >= 0), 32'd1);
  endtask

  initial begin
    int pa, pb;
    modelReset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();

    // Cold miss and sequential hits
    fetch(30'h10, pa, pb);
    chk("cold_pen", 0, 32'(pa), 32'd5);
    chk("cold_pen", 1, 32'(pb), 32'd5);
    chk("cold_miss_cnt", 0, 32'(missA), 32'd1);
    for (int i = 1; i < 4; i++) begin
      fetch(30'(32'h10 + i), pa, pb);
      chk("seq_hit_pen", 0, 32'(pa), 32'd0);
    end
    chk("seq_hit_cnt", 0, 32'(hitA), 32'd4);

    // LRU replacement in set 4
    fetch(30'h50, pa, pb);
    chk("lru_fill50", 0, 32'(pa), 32'd5);
    fetch(30'h10, pa, pb);
    chk("lru_hit10", 0, 32'(pa), 32'd0);
    fetch(30'h90, pa, pb);
    fetch(30'h10, pa, pb);
    chk("lru_keep10", 0, 32'(pa), 32'd0);
    chk("dm_evict10", 1, 32'(pb), 32'd5);
    fetch(30'h50, pa, pb);
    chk("lru_evict50", 0, 32'(pa), 32'd5);

    // Flush in IDLE
    flush = 1'b1; step(); flush = 1'b0;
    fetch(30'h10, pa, pb);
    chk("flush_idle_miss", 0, 32'(pa), 32'd5);

    // Flush in IDLE alongside a hit, then flush during beat 2 of the refill
    cpuReq = 1'b1; cpuAddr = 30'h10; flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < 20 && !(mBusy[0] && mBeat[0] == 2); k++) step();
    flush = 1'b1; step(); flush = 1'b0; cpuReq = 1'b0;
    step();
    chk("abort_state", 0, 32'(dbgA), 32'd0);
    fetch(30'h10, pa, pb);
    chk("abort_refetch", 0, 32'(pa), 32'd5);

    // Reset during beat 1
    cpuReq = 1'b1; cpuAddr = 30'h20;
    step(); step();
    #2 reset = 1'b0;
    #1;
    chk("rst_mem_req", 0, 32'(memReqA), 32'd0);
    chk("rst_mem_addr", 0, {2'b00, memAddrA}, 32'd0);
    chk("rst_hit_cnt", 0, 32'(hitA), 32'd0);
    chk("rst_miss_cnt", 0, 32'(missA), 32'd0);
    modelReset();
    cpuReq = 1'b0;
    step();
    reset = 1'b1;
    fetch(30'h10, pa, pb);
    chk("rst_refetch", 0, 32'(pa), 32'd5);
    chk("rst_miss_cnt1", 0, 32'(missA), 32'd1);

    // Two wait states per beat
    waitCfg = 2;
    fetch(30'h30, pa, pb);
    chk("wait_pen", 0, 32'(pa), 32'd13);
    fetch(30'h33, pa, pb);
    chk("wait_hit", 0, 32'(pa), 32'd0);

    // Random traffic with conflicting tags, occasional flushes, varying waits
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) waitCfg = $urandom_range(0, 2);
      cpuReq  = ($urandom_range(0, 3) != 0);
      cpuAddr = 30'($urandom_range(0, 511));
      flush   = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0; cpuReq = 1'b0; waitCfg = 0;
    step();

    // Counter saturation on the 4-bit instance
    fetch(30'h10, pa, pb);
    cpuReq = 1'b1; cpuAddr = 30'h10;
    repeat (20) step();
    cpuReq = 1'b0;
    step();
    chk("hit_sat", 1, 32'(hitB), 32'd15);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
